hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage RISC-V pipeline.
- The forwarding path resolves RAW hazards by supplying data. This block handles the hazards forwarding cannot resolve:
  - load-use dependency: inserts one bubble;
  - data-memory wait: freezes the whole pipeline;
  - taken branch: flushes IF/ID and ID/EX.
- Sits in ID/EX control. It drives the PC enable, the pipeline-register enables, and the bubble/flush inputs. It also keeps saturating event counters for performance debug.

Parameters:
- CNT_W, 32: width of each event counter.
- MEM_TIMEOUT, 16: number of consecutive freeze cycles after which mem_error is raised (minimum 2).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- IF_ID_Rs1  in  5  rs1 of the instruction in the ID stage.
- IF_ID_Rs2  in  5  rs2 of the instruction in the ID stage.
- IF_ID_UsesRs1  in  1  ID instruction reads rs1.
- IF_ID_UsesRs2  in  1  ID instruction reads rs2.
- ID_EX_Rd  in  5  destination register of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Write  out  1  ID/EX register enable.
- EX_MEM_Write  out  1  EX/MEM register enable.
- ID_EX_Bubble  out  1  load zeros into the ID/EX control fields.
- IF_ID_Flush  out  1  clear IF/ID to a NOP.
- ID_EX_Flush  out  1  clear ID/EX to a NOP.
- MEM_WB_Bubble  out  1  insert a NOP into MEM/WB.
- mem_error  out  1  sticky memory-timeout flag.
- load_stall_cnt  out  CNT_W  number of load-use bubbles inserted.
- freeze_cnt  out  CNT_W  number of freeze cycles.
- flush_cnt  out  CNT_W  number of branch flush events.

Behaviour:
- Signals are evaluated in a fixed priority order. The control outputs are combinational (Mealy) from the current state and inputs; the state, wait counter, error flag and event counters are registered.
- freeze = mem_req & !dmem_ready. It has the highest priority and is independent of state.
  - While freeze=1:
    - PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write are all 0.
    - MEM_WB_Bubble is 1.
    - All flush and bubble outputs other than MEM_WB_Bubble are 0.
  - A taken branch held in EX during a freeze is flushed on the first unfrozen cycle, because branch_taken is still asserted then.
- flush = !freeze & branch_taken. It sets IF_ID_Flush=1 and ID_EX_Flush=1 for that cycle.
  - All enables stay 1.
  - It overrides load-use, since the dependent instruction is discarded.
- luh (load-use hazard) = ID_EX_MemRead & (ID_EX_Rd != 0) & ((IF_ID_UsesRs1 & ID_EX_Rd==IF_ID_Rs1) | (IF_ID_UsesRs2 & ID_EX_Rd==IF_ID_Rs2)).
- stall = !freeze & !flush & luh & (state==RUN). It sets PCWrite=0, IF_ID_Write=0 and ID_EX_Bubble=1 for that cycle.
- Default (none of the above): all enables are 1 and all bubble/flush outputs are 0.
- State machine, registered:
  - States: RUN, LOAD_STALL, MEM_WAIT. Reset state is RUN.
  - RUN goes to LOAD_STALL on stall, to MEM_WAIT on freeze, and otherwise stays in RUN.
  - LOAD_STALL suppresses luh, which guarantees a stall of exactly one cycle. It goes to MEM_WAIT on freeze, otherwise back to RUN.
  - MEM_WAIT stays in MEM_WAIT while freeze=1 and returns to RUN when freeze=0.
  - The cycle on which the FSM leaves MEM_WAIT uses the normal RUN evaluation for its outputs.
- Wait counter:
  - wait_cnt counts consecutive freeze cycles and clears on any non-freeze cycle.
  - When a freeze cycle occurs with wait_cnt==MEM_TIMEOUT-1, mem_error is set on the next clock edge.
  - mem_error stays set until reset. The freeze itself continues as long as dmem_ready stays low.
- Event counters:
  - load_stall_cnt increments on each stall cycle, freeze_cnt on each freeze cycle, flush_cnt on each flush cycle.
  - All saturate at all-ones; they never wrap.
- Reset:
  - Synchronous; it overrides everything, including in the middle of MEM_WAIT.
  - State returns to RUN; wait_cnt, mem_error and all counters go to 0.
  - While reset=1 the outputs read as the default values (all enables 1, all bubble/flush 0).
- Simultaneous events: freeze takes priority over flush, and flush over stall. Only one class of action is taken per cycle.

Decomposition:
- Shared package: state encodings (HZ_RUN=2'd0, HZ_LOAD_STALL=2'd1, HZ_MEM_WAIT=2'd2) and the constant REG_X0=5'd0.
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count). It is instantiated three times.

Test Plan:
1. Load-use on rs1, with ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs1=5, IF_ID_UsesRs1=1 held for 2 cycles.
   - Cycle 0: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
   - Cycle 1: defaults, because LOAD_STALL suppresses luh.
   - load_stall_cnt=1.
2. Same as test 1 but with ID_EX_Rd=0, or with IF_ID_UsesRs1=0 -> no stall, load_stall_cnt stays 0.
3. mem_req=1 with dmem_ready=0 for 3 cycles, then 1.
   - Cycles 0-2: all enables 0 and MEM_WB_Bubble=1.
   - Cycle 3: defaults, state returns to RUN.
   - freeze_cnt=3, mem_error=0.
4. branch_taken=1 together with a load-use condition -> IF_ID_Flush=1, ID_EX_Flush=1, ID_EX_Bubble=0, PCWrite=1; flush_cnt=1, load_stall_cnt=0.
5. MEM_TIMEOUT=4, with mem_req=1 and dmem_ready=0 held.
   - mem_error=1 from cycle 4 onward.
   - It stays 1 after dmem_ready rises, until reset.
6. Reset asserted for 1 cycle during MEM_WAIT at cycle 2.
   - Next cycle: state RUN, all counters 0, mem_error=0.
   - With mem_req=0, the outputs are the defaults.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared state encodings and constants for the hazard stall unit
package hazard_stall_unit_pkg;
  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MEM_WAIT   = 2'd2
  } hz_state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: pipeline hazard inputs, stall/flush controls and debug counters
interface hazard_stall_unit_if #(parameter int CNT_W = 32);
  logic [4:0] IF_ID_Rs1;
  logic [4:0] IF_ID_Rs2;
  logic IF_ID_UsesRs1;
  logic IF_ID_UsesRs2;
  logic [4:0] ID_EX_Rd;
  logic ID_EX_MemRead;
  logic branch_taken;
  logic mem_req;
  logic dmem_ready;
  logic PCWrite;
  logic IF_ID_Write;
  logic ID_EX_Write;
  logic EX_MEM_Write;
  logic ID_EX_Bubble;
  logic IF_ID_Flush;
  logic ID_EX_Flush;
  logic MEM_WB_Bubble;
  logic mem_error;
  logic [CNT_W-1:0] load_stall_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output IF_ID_Rs1, IF_ID_Rs2, IF_ID_UsesRs1, IF_ID_UsesRs2, ID_EX_Rd, ID_EX_MemRead,
           branch_taken, mem_req, dmem_ready,
    input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble, IF_ID_Flush,
           ID_EX_Flush, MEM_WB_Bubble, mem_error, load_stall_cnt, freeze_cnt, flush_cnt
  );
  modport slave (
    input  IF_ID_Rs1, IF_ID_Rs2, IF_ID_UsesRs1, IF_ID_UsesRs2, ID_EX_Rd, ID_EX_MemRead,
           branch_taken, mem_req, dmem_ready,
    output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble, IF_ID_Flush,
           ID_EX_Flush, MEM_WB_Bubble, mem_error, load_stall_cnt, freeze_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use bubble, data-memory freeze and branch flush control
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  hazard_stall_unit_if.slave hz
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT - 1);
  hz_state_e state;
  logic [WW-1:0] wait_cnt;
  logic err, luh, fz, fl, st;
  always_comb begin
    luh = hz.ID_EX_MemRead && hz.ID_EX_Rd != REG_X0 &&
          ((hz.IF_ID_UsesRs1 && hz.ID_EX_Rd == hz.IF_ID_Rs1) ||
           (hz.IF_ID_UsesRs2 && hz.ID_EX_Rd == hz.IF_ID_Rs2));
    fz = !reset && hz.mem_req && !hz.dmem_ready;
    fl = !reset && !fz && hz.branch_taken;
    // leaving MEM_WAIT evaluates like RUN; only LOAD_STALL masks the hazard
    st = !reset && !fz && !fl && luh && state != HZ_LOAD_STALL;
  end
  assign hz.PCWrite       = !(fz || st);
  assign hz.IF_ID_Write   = !(fz || st);
  assign hz.ID_EX_Write   = !fz;
  assign hz.EX_MEM_Write  = !fz;
  assign hz.ID_EX_Bubble  = st;
  assign hz.IF_ID_Flush   = fl;
  assign hz.ID_EX_Flush   = fl;
  assign hz.MEM_WB_Bubble = fz;
  assign hz.mem_error     = err;
  always_ff @(posedge clk)
    if (reset) begin
      state    <= HZ_RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= fz ? HZ_MEM_WAIT : st ? HZ_LOAD_STALL : HZ_RUN;
      wait_cnt <= !fz ? '0 : wait_cnt == WAIT_MAX ? wait_cnt : wait_cnt + WW'(1);
      if (fz && wait_cnt == WAIT_MAX) err <= 1'b1;
    end
  sat_counter #(.W(CNT_W)) u_load_stall_cnt (.clk(clk), .reset(reset), .inc(st), .count(hz.load_stall_cnt));
  sat_counter #(.W(CNT_W)) u_freeze_cnt     (.clk(clk), .reset(reset), .inc(fz), .count(hz.freeze_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt      (.clk(clk), .reset(reset), .inc(fl), .count(hz.flush_cnt));
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed scoreboard bench for the hazard stall unit
module tb_hazard_stall_unit;
  localparam int CW = 3;
  // {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble}
  localparam logic [7:0] DEF = 8'b1111_0000;
  localparam logic [7:0] STL = 8'b0011_1000;
  localparam logic [7:0] FRZ = 8'b0000_0001;
  localparam logic [7:0] FLS = 8'b1111_0110;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  string tag_q[$];
  logic [7:0] ctrl;
  hazard_stall_unit_if #(.CNT_W(CW)) hz ();
  hazard_stall_unit #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .hz(hz));
  always #5 clk = ~clk;
  assign ctrl = {hz.PCWrite, hz.IF_ID_Write, hz.ID_EX_Write, hz.EX_MEM_Write,
                 hz.ID_EX_Bubble, hz.IF_ID_Flush, hz.ID_EX_Flush, hz.MEM_WB_Bubble};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    chk(tag_q.pop_front(), 32'(ctrl), 32'(exp_q.pop_front()));
    @(negedge clk);
  endtask
  task automatic cnts(input string tag, input int ls, input int fr, input int fl, input logic me);
    chk({tag, "_lscnt"}, 32'(hz.load_stall_cnt), 32'(ls));
    chk({tag, "_frcnt"}, 32'(hz.freeze_cnt), 32'(fr));
    chk({tag, "_flcnt"}, 32'(hz.flush_cnt), 32'(fl));
    chk({tag, "_merr"}, 32'(hz.mem_error), 32'(me));
  endtask
  task automatic idle();
    hz.IF_ID_Rs1 = 5'd0; hz.IF_ID_Rs2 = 5'd0; hz.IF_ID_UsesRs1 = 1'b0; hz.IF_ID_UsesRs2 = 1'b0;
    hz.ID_EX_Rd = 5'd0; hz.ID_EX_MemRead = 1'b0; hz.branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.dmem_ready = 1'b1;
  endtask
  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1);
    hz.ID_EX_MemRead = 1'b1; hz.ID_EX_Rd = rd; hz.IF_ID_Rs1 = rs1; hz.IF_ID_UsesRs1 = u1;
  endtask
  initial begin
    idle();
    @(negedge clk);
    hz.mem_req = 1'b1; hz.dmem_ready = 1'b0;
    cyc(DEF, "reset_outputs");
    reset = 1'b0; idle();
    cnts("after_reset", 0, 0, 0, 1'b0);
    load_use(5'd5, 5'd5, 1'b1);
    cyc(STL, "lu_rs1_c0");
    cyc(DEF, "lu_rs1_c1");
    cnts("lu_rs1", 1, 0, 0, 1'b0);
    idle();
    cyc(DEF, "lu_gap");
    hz.ID_EX_MemRead = 1'b1; hz.ID_EX_Rd = 5'd7; hz.IF_ID_Rs2 = 5'd7; hz.IF_ID_UsesRs2 = 1'b1;
    cyc(STL, "lu_rs2_c0");
    cyc(DEF, "lu_rs2_c1");
    idle();
    load_use(5'd0, 5'd0, 1'b1);
    cyc(DEF, "lu_x0");
    load_use(5'd5, 5'd5, 1'b0);
    cyc(DEF, "lu_unused_rs1");
    load_use(5'd5, 5'd5, 1'b1); hz.ID_EX_MemRead = 1'b0;
    cyc(DEF, "no_load");
    cnts("no_stall", 2, 0, 0, 1'b0);
    idle();
    for (int r = 0; r < 2; r++) begin
      hz.mem_req = 1'b1; hz.dmem_ready = 1'b0;
      for (int k = 0; k < 3; k++) cyc(FRZ, "freeze");
      hz.dmem_ready = 1'b1;
      cyc(DEF, "freeze_release");
    end
    cnts("freeze", 2, 6, 0, 1'b0);
    idle();
    load_use(5'd5, 5'd5, 1'b1); hz.branch_taken = 1'b1;
    cyc(FLS, "flush_over_lu");
    cnts("flush", 2, 6, 1, 1'b0);
    idle();
    hz.branch_taken = 1'b1; hz.mem_req = 1'b1; hz.dmem_ready = 1'b0;
    cyc(FRZ, "freeze_over_branch");
    hz.dmem_ready = 1'b1;
    cyc(FLS, "branch_after_freeze");
    cnts("frz_branch", 2, 7, 2, 1'b0);
    idle();
    reset = 1'b1;
    cyc(DEF, "reset_pulse");
    reset = 1'b0;
    hz.mem_req = 1'b1; hz.dmem_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cyc(FRZ, "timeout_freeze");
      chk("timeout_merr", 32'(hz.mem_error), 32'(k >= 3));
    end
    chk("freeze_saturate", 32'(hz.freeze_cnt), 32'(7));
    hz.dmem_ready = 1'b1;
    cyc(DEF, "timeout_release");
    cyc(DEF, "timeout_idle");
    cnts("sticky", 0, 7, 0, 1'b1);
    reset = 1'b1;
    cyc(DEF, "reset_clear");
    reset = 1'b0;
    hz.dmem_ready = 1'b0;
    cyc(FRZ, "mid_freeze0");
    cyc(FRZ, "mid_freeze1");
    reset = 1'b1;
    cyc(DEF, "reset_in_mem_wait");
    reset = 1'b0; idle();
    cnts("post_reset", 0, 0, 0, 1'b0);
    cyc(DEF, "post_reset_default");
    load_use(5'd9, 5'd9, 1'b1);
    cyc(STL, "post_reset_run");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
